// File: rtl/hazard_sched_ctrl.sv
// Decode/execute hazard scheduler: load-use bubbles, multiply freeze sequencing,
// memory-stall merge and redirect flushes. Optional counters: HAZ_PERF_CNT_EN.
module hazard_sched_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       D_rs1,
  input  logic [4:0]       D_rs2,
  input  logic             D_use_rs1,
  input  logic             D_use_rs2,
  input  logic             EX_ld,
  input  logic             EX_we,
  input  logic [4:0]       EX_rd,
  input  logic             EX_mul,
  input  logic             EX_taken,
  input  logic             mem_stall_req,
  output logic             F_stall,
  output logic             D_flush,
  output logic             stall_D,
  output logic             MEM_stall,
  output logic             mul_busy,
  output logic [CNT_W-1:0] perf_ldu,
  output logic [CNT_W-1:0] perf_mul,
  output logic [CNT_W-1:0] perf_mem,
  output logic [CNT_W-1:0] perf_flush
);

  localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [CW-1:0] LAST = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam bit MUL_SEQ = (MUL_LAT > 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] MUL  = 1'b1;

  logic [0:0]    state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          ldu, entry, freeze, flush, bubble, last;

  always_comb begin
    ldu = EX_ld & EX_we & (EX_rd != 5'd0) &
          ((D_use_rs1 & (D_rs1 == EX_rd)) | (D_use_rs2 & (D_rs2 == EX_rd)));
    entry  = (state_reg == IDLE) & EX_mul & MUL_SEQ & ~mem_stall_req;
    last   = (state_reg == MUL) & (cnt_reg == LAST);
    freeze = entry | ((state_reg == MUL) & (cnt_reg < LAST));
    // A redirect coinciding with a multiply waits until the multiply is done.
    flush  = EX_taken & ~EX_mul & ~mem_stall_req & ~freeze;
    // A redirect squashes the D instruction, so its load-use hazard is moot.
    bubble = ldu & ~mem_stall_req & ~freeze & ~EX_taken;
  end

  // Outputs are forced low while reset is asserted, independent of inputs.
  always_comb begin
    MEM_stall = rst_n & (mem_stall_req | freeze);
    F_stall   = rst_n & (mem_stall_req | freeze | bubble);
    D_flush   = rst_n & flush;
    stall_D   = rst_n & bubble;
    mul_busy  = rst_n & ((state_reg == MUL) | entry);
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    if (!mem_stall_req) begin
      if (entry) begin
        state_next = MUL;
        cnt_next   = ONE;
      end else if (state_reg == MUL) begin
        if (last) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [3:0]       perf_inc;
  logic [CNT_W-1:0] perf_reg [4];

  assign perf_inc = {D_flush, (rst_n & mem_stall_req), (rst_n & freeze & ~mem_stall_req), stall_D};

  for (genvar gi = 0; gi < 4; gi++) begin : g_perf
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        perf_reg[gi] <= '0;
      else if (perf_inc[gi] && (perf_reg[gi] != {CNT_W{1'b1}}))
        perf_reg[gi] <= perf_reg[gi] + 1'b1;
    end
  end

  assign perf_ldu   = perf_reg[0];
  assign perf_mul   = perf_reg[1];
  assign perf_mem   = perf_reg[2];
  assign perf_flush = perf_reg[3];
`else
  assign perf_ldu   = '0;
  assign perf_mul   = '0;
  assign perf_mem   = '0;
  assign perf_flush = '0;
`endif

endmodule
